// File: rtl/data_ram.sv
// data_ram: byte-enabled word RAM with registered read, range check and write-first bypass.
// Define DATA_RAM_CLEAR_EN to zero every word with a one-word-per-cycle sweep after reset.
module data_ram #(
    parameter int          DATA_WIDTH = 32,
    parameter int          DEPTH      = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    MemWrite,
    input  logic [DATA_WIDTH/8-1:0] ByteEn,
    input  logic [31:0]             A,
    input  logic [DATA_WIDTH-1:0]   WriteData,
    output logic [DATA_WIDTH-1:0]   ReadData,
    output logic                    AddrErr,
    output logic                    Busy
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam int AW  = $clog2(DEPTH);
    // 33-bit upper bound so a window ending at 32'hFFFFFFFF does not wrap
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH * NB);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q, rd_d, merged, wr_word;
    logic                  err_q, err_d;
    logic [AW-1:0]         idx, wr_idx;
    logic [31:0]           off;
    logic                  in_range, wr_en;

    assign off      = A - BASE_ADDR;
    assign idx      = AW'(off >> OFF);
    assign in_range = ({1'b0, A} >= {1'b0, BASE_ADDR}) && ({1'b0, A} < LIMIT);

    // Addressed word with the enabled bytes replaced; feeds both the array and the write-first read path
    always_comb begin
        merged = mem[idx];
        for (int i = 0; i < NB; i++)
            if (MemWrite && ByteEn[i]) merged[8*i +: 8] = WriteData[8*i +: 8];
    end

`ifdef DATA_RAM_CLEAR_EN
    typedef enum logic {CLEAR, READY} state_t;
    state_t        state_q, state_d;
    logic [AW-1:0] clr_q, clr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLEAR;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        if (state_q == CLEAR) begin
            clr_d = clr_q + 1'b1;
            if (clr_q == AW'(DEPTH - 1)) state_d = READY;
        end
    end

    assign Busy    = (state_q == CLEAR);
    assign wr_en   = Busy || (MemWrite && in_range);
    assign wr_idx  = Busy ? clr_q : idx;
    assign wr_word = Busy ? '0 : merged;
`else
    assign Busy    = 1'b0;
    assign wr_en   = MemWrite && in_range;
    assign wr_idx  = idx;
    assign wr_word = merged;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_word;
    end

    always_comb begin
        rd_d  = '0;
        err_d = 1'b0;
        if (!Busy) begin
            rd_d  = in_range ? merged : '0;
            err_d = !in_range;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            err_q <= err_d;
        end
    end

    assign ReadData = rd_q;
    assign AddrErr  = err_q;
endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter DEPTH, default 1024: number of words; SHALL be a power of two, minimum 2.
REQ-003 Parameter BASE_ADDR, default 32'h1000: byte address of word 0.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port MemWrite, input, 1: write request for the current cycle.
REQ-007 Port ByteEn, input, DATA_WIDTH/8: per-byte write mask; bit i enables WriteData[8i+7:8i].
REQ-008 Port A, input, 32: byte address.
REQ-009 Port WriteData, input, DATA_WIDTH: write data.
REQ-010 Port ReadData, output, DATA_WIDTH: registered read data.
REQ-011 Port AddrErr, output, 1: registered flag; 1 when the previous cycle's A was out of range.
REQ-012 Port Busy, output, 1: 1 while the clear sweep runs; no access is accepted while 1.

Function
REQ-013 Word index SHALL be (A - BASE_ADDR) >> log2(DATA_WIDTH/8); low byte-offset bits ignored, no misalignment error.
REQ-014 A is in range when BASE_ADDR <= A < BASE_ADDR + DEPTH*DATA_WIDTH/8; comparison in 33-bit arithmetic, so no wrap at 32'hFFFFFFFF.
REQ-015 Read latency SHALL be 1 cycle: ReadData after edge N reflects the word addressed by A before edge N.
REQ-016 Write: MemWrite=1, Busy=0, A in range at an edge updates the enabled bytes only; ByteEn=0 writes nothing.
REQ-017 Read during write to the same word SHALL be write-first: ReadData shows merged new data after that edge.
REQ-018 Out-of-range A: write ignored, ReadData <= 0, AddrErr <= 1; in-range A sets AddrErr <= 0.
REQ-019 FSM states CLEAR and READY; CLEAR zeroes one word per cycle, index 0 to DEPTH-1, then enters READY.
REQ-020 In CLEAR: Busy=1, MemWrite ignored, ReadData held 0, AddrErr held 0.
REQ-021 CLEAR SHALL last exactly DEPTH cycles after reset release; Busy falls on the edge that writes word DEPTH-1.
REQ-022 READY SHALL persist until reset; no other exit.

Reset
REQ-023 Assertion of rst SHALL immediately force ReadData=0, AddrErr=0, clear index=0, and the FSM state per REQ-028/029.
REQ-024 Reset asserted mid-sweep or mid-write SHALL abort the operation; the sweep restarts from word 0 on release.
REQ-025 Memory array contents are not reset directly; zeroing is performed only by the CLEAR sweep.
REQ-026 The first edge after rst deassertion SHALL be treated as a normal edge; no extra synchronisation cycle inside the block.

Configuration
REQ-027 Macro DATA_RAM_CLEAR_EN selects the power-on clear sweep.
REQ-028 Defined: reset enters CLEAR; Busy=1 per REQ-019 to REQ-021.
REQ-029 Undefined: reset enters READY directly; Busy tied 0; contents undefined until written; CLEAR logic absent.

Verification
REQ-030 With CLEAR_EN: release rst, hold A=32'h1000 -> Busy=1 for exactly 1024 cycles, then read of 32'h1000 and 32'h1FFC returns 0.
REQ-031 Write 32'h13FF to 32'h1000 and 32'h100 to 32'h1004, ByteEn=4'hF -> reads return 32'h13FF and 32'h100, 1-cycle latency.
REQ-032 Word 32'h1000 = 32'h13FF; write 32'hAABBCCDD with ByteEn=4'b0101 -> read returns 32'h00BB13DD.
REQ-033 Write 32'h55 to 32'h0FFC, then read 32'h2000 -> AddrErr=1, ReadData=0, no word altered; next in-range read clears AddrErr.
REQ-034 Simultaneous write 32'h1234 and read of 32'h1008 -> ReadData=32'h1234 on the following cycle.
REQ-035 Assert rst at sweep cycle 500, release -> Busy=1 for a full 1024 further cycles; MemWrite during Busy has no effect.
